// File: rtl/alu_operand_seq_pkg.sv
// Shared definitions for the ALU operand sequencer.
//   WIDTH   : data / shared-bus width
//   state_t : sequencer state encoding (ST_IDLE .. ST_DONE)
package alu_operand_seq_pkg;

    localparam int WIDTH = 8;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GET_A = 3'd1,
        ST_GET_B = 3'd2,
        ST_EXEC  = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

endpackage

// File: rtl/alu_operand_seq_operand_reg.sv
// operand_reg: WIDTH-bit register with async active-high clear and a
// synchronous load enable.
//   clk  : system clock, rising edge
//   clr  : asynchronous clear to zero, active-high
//   load : when high, q takes d at the next rising edge
//   d    : data in
//   q    : registered value
module operand_reg #(
    parameter int WIDTH = alu_operand_seq_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            q <= '0;
        end else if (load) begin
            q <= d;
        end
    end

endmodule

// File: rtl/alu_operand_seq.sv
// alu_operand_seq: bus-side sequencer for the adder/subtractor ALU.
// Pulls operand A then operand B off the shared bus, enables the ALU
// tristate driver for one cycle, and captures the result plus carry/zero
// flags from the bus into the accumulator.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_IDLE  | ready for start; acc/flags hold the last result
// ST_GET_A | waiting for bus_valid to capture operand A
// ST_GET_B | waiting for bus_valid to capture operand B
// ST_EXEC  | ALU drives the bus for one cycle; result captured at exit
// ST_DONE  | one-cycle done pulse, then back to idle
//
// Ports:
//   clk, clr            : clock (rising edge), async active-high reset
//   start, sub_req      : operation request (only in idle) and add/sub select
//   ready, busy         : idle indicator and its complement
//   bus_in, bus_valid   : resolved shared bus and operand-valid qualifier
//   alu_a, alu_b        : operand registers to the ALU
//   alu_sub             : latched add/sub select to the ALU
//   alu_out_en          : ALU tristate output enable (high only in ST_EXEC)
//   alu_cout            : ALU carry out
//   acc                 : accumulator, last committed result
//   carry_flag          : carry captured with the result
//   zero_flag           : captured result was zero
//   done                : one-cycle pulse after a commit
//   bus_conflict        : sticky, bus_valid seen while the ALU owned the bus
module alu_operand_seq #(
    parameter int WIDTH = alu_operand_seq_pkg::WIDTH
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             start,
    input  logic             sub_req,
    output logic             ready,
    output logic             busy,
    input  logic [WIDTH-1:0] bus_in,
    input  logic             bus_valid,
    output logic [WIDTH-1:0] alu_a,
    output logic [WIDTH-1:0] alu_b,
    output logic             alu_sub,
    output logic             alu_out_en,
    input  logic             alu_cout,
    output logic [WIDTH-1:0] acc,
    output logic             carry_flag,
    output logic             zero_flag,
    output logic             done,
    output logic             bus_conflict
);

    import alu_operand_seq_pkg::*;

    state_t state_q;
    state_t state_d;

    logic op_sub_q;
    logic load_a;
    logic load_b;
    logic load_acc;
    logic out_en_q;
    logic done_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        load_a   = 1'b0;
        load_b   = 1'b0;
        load_acc = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (start) begin
                    state_d = ST_GET_A;
                end
            end
            ST_GET_A: begin
                if (bus_valid) begin
                    load_a  = 1'b1;
                    state_d = ST_GET_B;
                end
            end
            ST_GET_B: begin
                if (bus_valid) begin
                    load_b  = 1'b1;
                    state_d = ST_EXEC;
                end
            end
            ST_EXEC: begin
                load_acc = 1'b1;
                state_d  = ST_DONE;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Output enable and done come straight from flops (loaded from the
    // next-state decode) so the tristate enable never glitches on a
    // multi-bit state transition.
    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            out_en_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            out_en_q <= (state_d == ST_EXEC);
            done_q   <= (state_d == ST_DONE);
        end
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            op_sub_q     <= 1'b0;
            carry_flag   <= 1'b0;
            zero_flag    <= 1'b0;
            bus_conflict <= 1'b0;
        end else begin
            if (state_q == ST_IDLE && start) begin
                op_sub_q     <= sub_req;
                bus_conflict <= 1'b0;
            end
            if (load_acc) begin
                carry_flag <= alu_cout;
                zero_flag  <= (bus_in == '0);
                // An external driver fighting the ALU is flagged, but the
                // committed result is still whatever the bus resolved to.
                if (bus_valid) begin
                    bus_conflict <= 1'b1;
                end
            end
        end
    end

    operand_reg #(.WIDTH(WIDTH)) u_reg_a (
        .clk  (clk),
        .clr  (clr),
        .load (load_a),
        .d    (bus_in),
        .q    (alu_a)
    );

    operand_reg #(.WIDTH(WIDTH)) u_reg_b (
        .clk  (clk),
        .clr  (clr),
        .load (load_b),
        .d    (bus_in),
        .q    (alu_b)
    );

    operand_reg #(.WIDTH(WIDTH)) u_reg_acc (
        .clk  (clk),
        .clr  (clr),
        .load (load_acc),
        .d    (bus_in),
        .q    (acc)
    );

    assign alu_sub    = op_sub_q;
    assign alu_out_en = out_en_q;
    assign done       = done_q;
    assign ready      = (state_q == ST_IDLE);
    assign busy       = (state_q != ST_IDLE);

endmodule
